hazard_unit: RTL and testbench

Parametrised pipeline hazard controller for the 5-stage RISC-V core. It supersedes the stand-alone forwarding unit and adds the following:
- load-use stall generation with a configurable data-memory read latency;
- taken-branch flush of the IF/ID, ID/EX and EX/MEM buffers;
- saturating stall/flush performance counters.

It sits beside the pipeline buffers. It drives the PC write-enable, the buffer write-enables and flushes, and the two EX-stage operand forwarding muxes.

---
 rtl/pipe_pkg.sv | 15 +
 rtl/fwd_select.sv | 25 ++
 rtl/hazard_unit.sv | 151 +++++++++++++++
 tb/tb_hazard_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types for the pipeline hazard controller
package pipe_pkg;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } hz_state_t;

endpackage

// File: rtl/fwd_select.sv
// rtl/fwd_select.sv - EX-stage operand forwarding priority comparator
module fwd_select
    import pipe_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] ex_rs,
    input  logic             mem_reg_write,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             wb_reg_write,
    input  logic [REG_W-1:0] wb_rd,
    output logic [1:0]       sel
);

    // Youngest producer (MEM) wins over WB; x0 is hard-wired zero and never forwarded
    always_comb begin
        sel = FWD_REG;
        if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs)) begin
            sel = FWD_MEM;
        end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - load-use stall, branch flush, forwarding and event counters
module hazard_unit
    import pipe_pkg::*;
#(
    parameter int REG_W    = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic             clk_div,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] ex_rs1,
    input  logic [REG_W-1:0] ex_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] mem_rd,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             mem_reg_write,
    input  logic             wb_reg_write,
    input  logic             branch_taken,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // bub_cnt only needs to hold LOAD_LAT-1 (the bubbles left after the first one)
    localparam int               BUB_W    = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
    localparam logic [BUB_W-1:0] BUB_INIT = BUB_W'(LOAD_LAT - 1);

    hz_state_t        state_q, state_d;
    logic [BUB_W-1:0] bub_cnt_q, bub_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic       lu;
    logic       stall;
    logic       flush;
    logic [1:0] fwd_a_raw;
    logic [1:0] fwd_b_raw;

    fwd_select #(.REG_W(REG_W)) u_fwd_a (
        .ex_rs         (ex_rs1),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .sel           (fwd_a_raw)
    );

    fwd_select #(.REG_W(REG_W)) u_fwd_b (
        .ex_rs         (ex_rs2),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .sel           (fwd_b_raw)
    );

    assign lu = ex_mem_read && (ex_rd != '0) &&
                ((id_use_rs1 && (ex_rd == id_rs1)) || (id_use_rs2 && (ex_rd == id_rs2)));

    // Event decode: a taken branch overrides any pending or new load-use stall
    always_comb begin
        flush = branch_taken;
        stall = !branch_taken && ((state_q == STALL) || lu);
    end

    // Next state: the first bubble is issued from RUN, the remaining LOAD_LAT-1 from STALL
    always_comb begin
        state_d   = state_q;
        bub_cnt_d = bub_cnt_q;
        if (flush) begin
            state_d   = RUN;
            bub_cnt_d = '0;
        end else if (state_q == STALL) begin
            if (bub_cnt_q <= BUB_W'(1)) begin
                state_d   = RUN;
                bub_cnt_d = '0;
            end else begin
                bub_cnt_d = bub_cnt_q - BUB_W'(1);
            end
        end else if (lu && (LOAD_LAT > 1)) begin
            state_d   = STALL;
            bub_cnt_d = BUB_INIT;
        end
    end

    // Saturating event counters: hold at all-ones instead of wrapping
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // Pipeline control outputs; reset forces free-running flow with no forwarding
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        fwd_a       = FWD_REG;
        fwd_b       = FWD_REG;
        if (rst) begin
            fwd_a = fwd_a_raw;
            fwd_b = fwd_b_raw;
            if (flush) begin
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
            end else if (stall) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_flush = 1'b1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    // State, bubble counter and event counters; reset abandons any pending bubbles
    always_ff @(posedge clk_div) begin
        if (!rst) begin
            state_q     <= RUN;
            bub_cnt_q   <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            bub_cnt_q   <= bub_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - scoreboard bench for hazard_unit in three configurations
module tb_hazard_unit;

    logic clk_div = 1'b0;
    always #5 clk_div = ~clk_div;

    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic       id_use_rs1, id_use_rs2, ex_mem_read;
    logic       mem_reg_write, wb_reg_write, branch_taken;

    logic [1:0]  fwd_a [3];
    logic [1:0]  fwd_b [3];
    logic        pc_write [3];
    logic        ifid_write [3];
    logic        ifid_flush [3];
    logic        idex_flush [3];
    logic        exmem_flush [3];
    logic [31:0] sc0, fc0, sc1, fc1;
    logic [1:0]  sc2, fc2;

    hazard_unit #(.REG_W(5), .LOAD_LAT(1), .CNT_W(32)) u_dut0 (
        .clk_div(clk_div), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write), .branch_taken(branch_taken),
        .fwd_a(fwd_a[0]), .fwd_b(fwd_b[0]), .pc_write(pc_write[0]), .ifid_write(ifid_write[0]),
        .ifid_flush(ifid_flush[0]), .idex_flush(idex_flush[0]), .exmem_flush(exmem_flush[0]),
        .stall_cnt(sc0), .flush_cnt(fc0)
    );

    hazard_unit #(.REG_W(5), .LOAD_LAT(3), .CNT_W(32)) u_dut1 (
        .clk_div(clk_div), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write), .branch_taken(branch_taken),
        .fwd_a(fwd_a[1]), .fwd_b(fwd_b[1]), .pc_write(pc_write[1]), .ifid_write(ifid_write[1]),
        .ifid_flush(ifid_flush[1]), .idex_flush(idex_flush[1]), .exmem_flush(exmem_flush[1]),
        .stall_cnt(sc1), .flush_cnt(fc1)
    );

    hazard_unit #(.REG_W(5), .LOAD_LAT(3), .CNT_W(2)) u_dut2 (
        .clk_div(clk_div), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write), .branch_taken(branch_taken),
        .fwd_a(fwd_a[2]), .fwd_b(fwd_b[2]), .pc_write(pc_write[2]), .ifid_write(ifid_write[2]),
        .ifid_flush(ifid_flush[2]), .idex_flush(idex_flush[2]), .exmem_flush(exmem_flush[2]),
        .stall_cnt(sc2), .flush_cnt(fc2)
    );

    typedef struct {
        int         inst;
        logic [4:0] ctl;
        logic [1:0] fa;
        logic [1:0] fb;
        longint     sc;
        longint     fc;
    } exp_t;

    exp_t   sbq[$];
    int     checks   = 0;
    int     failures = 0;
    int     rem  [3];
    longint scnt [3];
    longint fcnt [3];
    int     ll   [3] = '{1, 3, 3};
    longint cmax [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd3};

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (mem_reg_write && mem_rd != 0 && mem_rd == rs) return 2'b10;
        if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic ref_lu();
        return ex_mem_read && ex_rd != 0 &&
               ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
    endfunction

    task automatic push_exp();
        exp_t e;
        logic st;
        for (int i = 0; i < 3; i++) begin
            st     = !branch_taken && (rem[i] > 0 || ref_lu());
            e.inst = i;
            if (!rst)              e.ctl = 5'b11000;
            else if (branch_taken) e.ctl = 5'b11111;
            else if (st)           e.ctl = 5'b00010;
            else                   e.ctl = 5'b11000;
            e.fa = rst ? ref_fwd(ex_rs1) : 2'b00;
            e.fb = rst ? ref_fwd(ex_rs2) : 2'b00;
            e.sc = scnt[i];
            e.fc = fcnt[i];
            sbq.push_back(e);
        end
    endtask

    task automatic pop_cmp();
        exp_t       e;
        logic [4:0] ctl;
        longint     sc, fc;
        for (int k = 0; k < 3; k++) begin
            if (sbq.size() == 0) begin
                chk("sb_empty", 0, 1);
            end else begin
                e   = sbq.pop_front();
                ctl = {pc_write[e.inst], ifid_write[e.inst], ifid_flush[e.inst],
                       idex_flush[e.inst], exmem_flush[e.inst]};
                case (e.inst)
                    0:       begin sc = sc0; fc = fc0; end
                    1:       begin sc = sc1; fc = fc1; end
                    default: begin sc = longint'(sc2); fc = longint'(fc2); end
                endcase
                chk($sformatf("i%0d_ctl", e.inst), longint'(ctl), longint'(e.ctl));
                chk($sformatf("i%0d_fwd_a", e.inst), longint'(fwd_a[e.inst]), longint'(e.fa));
                chk($sformatf("i%0d_fwd_b", e.inst), longint'(fwd_b[e.inst]), longint'(e.fb));
                chk($sformatf("i%0d_stall_cnt", e.inst), sc, e.sc);
                chk($sformatf("i%0d_flush_cnt", e.inst), fc, e.fc);
            end
        end
    endtask

    task automatic model_update();
        logic st;
        for (int i = 0; i < 3; i++) begin
            st = !branch_taken && (rem[i] > 0 || ref_lu());
            if (!rst) begin
                rem[i] = 0; scnt[i] = 0; fcnt[i] = 0;
            end else if (branch_taken) begin
                rem[i] = 0;
                if (fcnt[i] < cmax[i]) fcnt[i]++;
            end else if (st) begin
                if (scnt[i] < cmax[i]) scnt[i]++;
                if (rem[i] > 0) rem[i]--;
                else            rem[i] = ll[i] - 1;
            end
        end
    endtask

    task automatic cyc();
        push_exp();
        @(negedge clk_div);
        pop_cmp();
        model_update();
        @(posedge clk_div);
        #1;
    endtask

    task automatic clr();
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_mem_read = 0;
        mem_rd = 0; wb_rd = 0; mem_reg_write = 0; wb_reg_write = 0;
        branch_taken = 0; rst = 1;
    endtask

    task automatic hazard();
        ex_mem_read = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1;
    endtask

    task automatic rst_pulse();
        clr(); rst = 0; cyc(); rst = 1;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin rem[i] = 0; scnt[i] = 0; fcnt[i] = 0; end
        clr();
        rst = 0;
        @(posedge clk_div);
        #1;

        // reset forces outputs even with hazard and forwarding inputs active
        hazard(); mem_reg_write = 1; mem_rd = 5; ex_rs1 = 5; branch_taken = 1;
        rst = 0; cyc(); cyc();
        chk("rst_pc_write", longint'(pc_write[1]), 1);
        chk("rst_fwd_a", longint'(fwd_a[0]), 0);

        // forwarding priority
        clr();
        mem_rd = 5; wb_rd = 5; ex_rs1 = 5; ex_rs2 = 5; mem_reg_write = 1; wb_reg_write = 1;
        cyc();
        chk("fwd_mem_prio", longint'(fwd_a[0]), 2);
        mem_reg_write = 0; cyc();
        chk("fwd_wb", longint'(fwd_a[0]), 1);
        ex_rs1 = 0; cyc();
        chk("fwd_x0", longint'(fwd_a[0]), 0);
        chk("fwd_b_wb", longint'(fwd_b[0]), 1);

        // load-use: 1 bubble for LOAD_LAT=1, 3 bubbles for LOAD_LAT=3
        rst_pulse();
        hazard(); cyc();
        clr(); cyc(); cyc(); cyc();
        chk("lu_ll1_stalls", longint'(sc0), 1);
        chk("lu_ll3_stalls", longint'(sc1), 3);
        chk("lu_ll3_resumed", longint'(pc_write[1]), 1);

        // source not actually read: no stall
        hazard(); id_use_rs2 = 0; cyc();
        clr(); cyc();
        chk("no_use_no_stall", longint'(sc1), 3);

        // branch in the 2nd stall cycle aborts the stall
        rst_pulse();
        hazard(); cyc();
        clr(); branch_taken = 1; cyc();
        branch_taken = 0; cyc(); cyc();
        chk("br_abort_stall", longint'(sc1), 1);
        chk("br_abort_flush", longint'(fc1), 1);

        // simultaneous load-use and branch: flush only
        hazard(); branch_taken = 1; cyc();
        clr(); cyc();
        chk("simul_stall", longint'(sc1), 1);
        chk("simul_flush", longint'(fc1), 2);

        // saturation of a 2-bit counter
        branch_taken = 1;
        for (int n = 0; n < 5; n++) cyc();
        clr(); cyc();
        chk("sat_flush_cnt", longint'(fc2), 3);
        chk("wide_flush_cnt", longint'(fc0), 7);

        // one reset edge clears counters
        rst = 0; cyc();
        rst = 1; cyc();
        chk("rst_clr_flush", longint'(fc2), 0);
        chk("rst_clr_stall", longint'(sc1), 0);

        // random traffic against the model
        for (int n = 0; n < 200; n++) begin
            id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
            ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
            ex_rd  = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
            wb_rd  = 5'($urandom_range(0, 3));
            id_use_rs1 = 1'($urandom_range(0, 1)); id_use_rs2 = 1'($urandom_range(0, 1));
            ex_mem_read = 1'($urandom_range(0, 1));
            mem_reg_write = 1'($urandom_range(0, 1)); wb_reg_write = 1'($urandom_range(0, 1));
            branch_taken = ($urandom_range(0, 5) == 0);
            rst = ($urandom_range(0, 15) != 0);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
